// File: rtl/dm_arbiter_if.sv
// dm_arbiter_if: one requester port of the data-memory arbiter.
// master = requester side (CPU / debug loader), slave = arbiter side.
interface dm_arbiter_if;
    logic        req;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port arbiter (m0 = CPU, m1 = debug/loader) in front of a
// single-ported data RAM. Every transaction is IDLE -> GRANT -> ACK.
// Optional macro DM_ARBITER_RR_EN: round-robin tie-break through a
// last_grant register; when undefined, m0 wins every tie.
module dm_arbiter (
    input  logic                clk,
    input  logic                clr,
    dm_arbiter_if.slave         m0,
    dm_arbiter_if.slave         m1,
    output logic                ram_cs,
    output logic                ram_rd,
    output logic                ram_oe,
    output logic [7:0]          ram_addr,
    output logic [31:0]         ram_wdata,
    input  logic [31:0]         ram_rdata,
    output logic                busy,
    output logic [31:0]         xfer_count
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t      state;
    logic        grant_sel;
    logic        winner;
    logic        m0_ack_q;
    logic        m1_ack_q;
    logic [31:0] m0_rdata_q;
    logic [31:0] m1_rdata_q;
    logic        own_req;
    logic        own_we;
    logic [7:0]  own_addr;
    logic [31:0] own_wdata;
`ifdef DM_ARBITER_RR_EN
    logic        last_grant;
`endif

    // Arbitration: a lone requester always wins; ties use the configured policy.
    always_comb begin
`ifdef DM_ARBITER_RR_EN
        winner = (m0.req && m1.req) ? ~last_grant : m1.req;
`else
        winner = m1.req && !m0.req;
`endif
    end

    // Owner's live inputs; the non-owner port is never looked at.
    always_comb begin
        own_req   = grant_sel ? m1.req   : m0.req;
        own_we    = grant_sel ? m1.we    : m0.we;
        own_addr  = grant_sel ? m1.addr  : m0.addr;
        own_wdata = grant_sel ? m1.wdata : m0.wdata;
    end

    // RAM strobes: only in GRANT and only while the owner still requests,
    // so an abandoned access never reaches the RAM.
    always_comb begin
        ram_cs    = (state == GRANT) && own_req;
        ram_rd    = ram_cs && !own_we;
        ram_oe    = ram_rd;
        ram_addr  = (state == GRANT) ? own_addr  : 8'd0;
        ram_wdata = (state == GRANT) ? own_wdata : 32'd0;
        busy      = (state != IDLE);
    end

    assign m0.ack   = m0_ack_q;
    assign m1.ack   = m1_ack_q;
    assign m0.rdata = m0_rdata_q;
    assign m1.rdata = m1_rdata_q;

    // Transaction FSM with registered ack/rdata/count.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state      <= IDLE;
            grant_sel  <= 1'b0;
            m0_ack_q   <= 1'b0;
            m1_ack_q   <= 1'b0;
            m0_rdata_q <= 32'd0;
            m1_rdata_q <= 32'd0;
            xfer_count <= 32'd0;
`ifdef DM_ARBITER_RR_EN
            last_grant <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (m0.req || m1.req) begin
                        grant_sel <= winner;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (own_req) begin
                        if (!own_we) begin
                            if (grant_sel) m1_rdata_q <= ram_rdata;
                            else           m0_rdata_q <= ram_rdata;
                        end
                        m0_ack_q <= !grant_sel;
                        m1_ack_q <= grant_sel;
                        state    <= ACK;
                    end else begin
                        state <= IDLE;
                    end
                end
                ACK: begin
                    m0_ack_q   <= 1'b0;
                    m1_ack_q   <= 1'b0;
                    xfer_count <= xfer_count + 32'd1;
`ifdef DM_ARBITER_RR_EN
                    last_grant <= grant_sel;
`endif
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: randomized and directed bench for dm_arbiter with a
// transaction-level reference model (memory array + tie-break rule).
module tb_dm_arbiter;
    logic        clk = 1'b0;
    logic        clr;
    logic        ram_cs, ram_rd, ram_oe, busy;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata, ram_rdata, xfer_count;

    dm_arbiter_if m0_if ();
    dm_arbiter_if m1_if ();

    always #5 clk = ~clk;

    dm_arbiter dut (
        .clk        (clk),
        .clr        (clr),
        .m0         (m0_if),
        .m1         (m1_if),
        .ram_cs     (ram_cs),
        .ram_rd     (ram_rd),
        .ram_oe     (ram_oe),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .busy       (busy),
        .xfer_count (xfer_count)
    );

    // External RAM: combinational read, write on posedge when cs && !rd.
    logic [31:0] ram_mem [256];
    logic        mem_init;
    logic        pre_we;
    logic [7:0]  pre_addr;
    logic [31:0] pre_data;

    assign ram_rdata = ram_mem[ram_addr];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) ram_mem[i] <= 32'hC0DE_0000 + i;
        end else if (pre_we) begin
            ram_mem[pre_addr] <= pre_data;
        end else if (ram_cs && !ram_rd) begin
            ram_mem[ram_addr] <= ram_wdata;
        end
    end

    // Reference model
    logic [31:0] ref_mem [256];
    logic [31:0] exp_rdata [2];
    logic [31:0] exp_count;
    logic        ref_last;
    int          checks = 0;
    int          errors = 0;

    // Observations from one transaction
    logic        o_cs, o_rd, o_oe, o_busy_g, o_ack0, o_ack1, o_busy_i, o_ack_i;
    logic [7:0]  o_addr;
    logic [31:0] o_wdata, o_rd0, o_rd1, o_count;

    function automatic logic ref_pick(input logic r0, input logic r1);
        if (r0 && r1) begin
`ifdef DM_ARBITER_RR_EN
            return ~ref_last;
`else
            return 1'b0;
`endif
        end
        return r1;
    endfunction

    function automatic void ref_complete(input logic w, input logic we,
                                         input logic [7:0] a, input logic [31:0] d);
        if (we) ref_mem[a] = d;
        else    exp_rdata[w] = ref_mem[a];
        exp_count = exp_count + 32'd1;
        ref_last  = w;
    endfunction

    function automatic void ref_reset();
        exp_rdata[0] = 32'd0;
        exp_rdata[1] = 32'd0;
        exp_count    = 32'd0;
        ref_last     = 1'b1;
    endfunction

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk); @(negedge clk);
        pre_we = 1'b0;
        ref_mem[a] = d;
    endtask

    // Starts and ends at a negedge with the DUT idle; requests drop during the ack cycle.
    task automatic run_xfer(input logic r0, input logic r1, input logic w0, input logic w1,
                            input logic [7:0] a0, input logic [7:0] a1,
                            input logic [31:0] d0, input logic [31:0] d1);
        m0_if.req = r0; m0_if.we = w0; m0_if.addr = a0; m0_if.wdata = d0;
        m1_if.req = r1; m1_if.we = w1; m1_if.addr = a1; m1_if.wdata = d1;
        @(posedge clk); @(negedge clk);
        o_cs = ram_cs; o_rd = ram_rd; o_oe = ram_oe; o_addr = ram_addr;
        o_wdata = ram_wdata; o_busy_g = busy;
        @(posedge clk); @(negedge clk);
        o_ack0 = m0_if.ack; o_ack1 = m1_if.ack; o_rd0 = m0_if.rdata; o_rd1 = m1_if.rdata;
        m0_if.req = 1'b0; m1_if.req = 1'b0;
        @(posedge clk); @(negedge clk);
        o_busy_i = busy; o_ack_i = m0_if.ack | m1_if.ack; o_count = xfer_count;
    endtask

    task automatic test_reset();
        clr = 1'b1; mem_init = 1'b1; pre_we = 1'b0; pre_addr = 8'd0; pre_data = 32'd0;
        m0_if.req = 0; m0_if.we = 0; m0_if.addr = 0; m0_if.wdata = 0;
        m1_if.req = 0; m1_if.we = 0; m1_if.addr = 0; m1_if.wdata = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'hC0DE_0000 + i;
        ref_reset();
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (ram_cs !== 1'b0) begin errors++; $display("FAIL reset_cs got %b exp 0", ram_cs); end
        @(negedge clk); @(negedge clk);
        mem_init = 1'b0; clr = 1'b0;
        @(negedge clk);
        checks++; if ({ram_cs, ram_rd, ram_oe} !== 3'b000) begin errors++; $display("FAIL reset_strobes got %b exp 000", {ram_cs, ram_rd, ram_oe}); end
        checks++; if (ram_addr !== 8'd0) begin errors++; $display("FAIL reset_addr got %h exp 00", ram_addr); end
        checks++; if (ram_wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata got %h exp 0", ram_wdata); end
        checks++; if ({m0_if.ack, m1_if.ack} !== 2'b00) begin errors++; $display("FAIL reset_ack got %b exp 00", {m0_if.ack, m1_if.ack}); end
        checks++; if (m0_if.rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata0 got %h exp 0", m0_if.rdata); end
        checks++; if (m1_if.rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata1 got %h exp 0", m1_if.rdata); end
        checks++; if (xfer_count !== 32'd0) begin errors++; $display("FAIL reset_count got %h exp 0", xfer_count); end
    endtask

    task automatic test_single_read();
        preload(8'd5, 32'hDEAD_BEEF);
        run_xfer(1, 0, 0, 0, 8'd5, 8'd9, 32'd0, 32'd0);
        ref_complete(1'b0, 1'b0, 8'd5, 32'd0);
        checks++; if ({o_cs, o_rd, o_oe} !== 3'b111) begin errors++; $display("FAIL read_strobes got %b exp 111", {o_cs, o_rd, o_oe}); end
        checks++; if (o_addr !== 8'd5) begin errors++; $display("FAIL read_addr got %h exp 05", o_addr); end
        checks++; if (o_busy_g !== 1'b1) begin errors++; $display("FAIL read_busy got %b exp 1", o_busy_g); end
        checks++; if ({o_ack0, o_ack1} !== 2'b10) begin errors++; $display("FAIL read_ack got %b exp 10", {o_ack0, o_ack1}); end
        checks++; if (o_rd0 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_rdata got %h exp deadbeef", o_rd0); end
        checks++; if (o_count !== 32'd1) begin errors++; $display("FAIL read_count got %0d exp 1", o_count); end
        checks++; if ({o_busy_i, o_ack_i} !== 2'b00) begin errors++; $display("FAIL read_idle got %b exp 00", {o_busy_i, o_ack_i}); end
    endtask

    task automatic test_write_then_read();
        run_xfer(0, 1, 0, 1, 8'h33, 8'h10, 32'h0BAD_0BAD, 32'h1234_5678);
        ref_complete(1'b1, 1'b1, 8'h10, 32'h1234_5678);
        checks++; if ({o_cs, o_rd, o_oe} !== 3'b100) begin errors++; $display("FAIL wr_strobes got %b exp 100", {o_cs, o_rd, o_oe}); end
        checks++; if (o_addr !== 8'h10 || o_wdata !== 32'h1234_5678) begin errors++; $display("FAIL wr_bus got %h/%h exp 10/12345678", o_addr, o_wdata); end
        checks++; if ({o_ack0, o_ack1} !== 2'b01) begin errors++; $display("FAIL wr_ack got %b exp 01", {o_ack0, o_ack1}); end
        checks++; if (o_rd1 !== exp_rdata[1]) begin errors++; $display("FAIL wr_rdata_hold got %h exp %h", o_rd1, exp_rdata[1]); end
        run_xfer(1, 0, 0, 0, 8'h10, 8'h00, 32'd0, 32'd0);
        ref_complete(1'b0, 1'b0, 8'h10, 32'd0);
        checks++; if ({o_ack0, o_ack1} !== 2'b10) begin errors++; $display("FAIL rd_after_wr_ack got %b exp 10", {o_ack0, o_ack1}); end
        checks++; if (o_rd0 !== 32'h1234_5678) begin errors++; $display("FAIL rd_after_wr_data got %h exp 12345678", o_rd0); end
        checks++; if (o_count !== exp_count) begin errors++; $display("FAIL rd_after_wr_count got %0d exp %0d", o_count, exp_count); end
    endtask

    task automatic test_tie_hold();
        logic exp_w;
        exp_w = 1'b0;
        m0_if.req = 1; m0_if.we = 0; m0_if.addr = 8'h20; m0_if.wdata = 32'd0;
        m1_if.req = 1; m1_if.we = 0; m1_if.addr = 8'h21; m1_if.wdata = 32'd0;
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk); @(negedge clk);
            if (k % 3 == 1) begin
                exp_w = ref_pick(1'b1, 1'b1);
                checks++; if (ram_addr !== (exp_w ? 8'h21 : 8'h20)) begin errors++; $display("FAIL tie_addr cyc %0d got %h exp %h", k, ram_addr, exp_w ? 8'h21 : 8'h20); end
            end
            if (k % 3 == 2) begin
                ref_complete(exp_w, 1'b0, exp_w ? 8'h21 : 8'h20, 32'd0);
                checks++; if ({m0_if.ack, m1_if.ack} !== {~exp_w, exp_w}) begin errors++; $display("FAIL tie_ack cyc %0d got %b exp %b", k, {m0_if.ack, m1_if.ack}, {~exp_w, exp_w}); end
                checks++; if (m0_if.rdata !== exp_rdata[0] || m1_if.rdata !== exp_rdata[1]) begin errors++; $display("FAIL tie_rdata cyc %0d got %h/%h exp %h/%h", k, m0_if.rdata, m1_if.rdata, exp_rdata[0], exp_rdata[1]); end
            end else begin
                checks++; if ({m0_if.ack, m1_if.ack} !== 2'b00) begin errors++; $display("FAIL tie_noack cyc %0d got %b exp 00", k, {m0_if.ack, m1_if.ack}); end
            end
        end
        m0_if.req = 0; m1_if.req = 0;
        @(posedge clk); @(negedge clk);
        checks++; if (xfer_count !== exp_count) begin errors++; $display("FAIL tie_count got %0d exp %0d", xfer_count, exp_count); end
    endtask

    task automatic test_abandon();
        logic [31:0] cnt0;
        cnt0 = exp_count;
        m0_if.req = 1; m0_if.we = 1; m0_if.addr = 8'd7; m0_if.wdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        m0_if.req = 0;
        @(negedge clk);
        checks++; if (ram_cs !== 1'b0 || m0_if.ack !== 1'b0) begin errors++; $display("FAIL abandon_grant cs/ack got %b%b exp 00", ram_cs, m0_if.ack); end
        @(posedge clk); @(negedge clk);
        checks++; if (busy !== 1'b0 || m0_if.ack !== 1'b0) begin errors++; $display("FAIL abandon_idle busy/ack got %b%b exp 00", busy, m0_if.ack); end
        checks++; if (xfer_count !== cnt0) begin errors++; $display("FAIL abandon_count got %0d exp %0d", xfer_count, cnt0); end
        checks++; if (ram_mem[7] !== ref_mem[7]) begin errors++; $display("FAIL abandon_ram got %h exp %h", ram_mem[7], ref_mem[7]); end
    endtask

    task automatic test_clr_mid_grant();
        preload(8'd3, 32'h1111_1111);
        m0_if.req = 1; m0_if.we = 1; m0_if.addr = 8'd3; m0_if.wdata = 32'hAAAA_AAAA;
        @(posedge clk); #2;
        clr = 1'b1;
        #1;
        ref_reset();
        checks++; if ({ram_cs, ram_rd, ram_oe, busy} !== 4'b0000) begin errors++; $display("FAIL clr_strobes got %b exp 0000", {ram_cs, ram_rd, ram_oe, busy}); end
        checks++; if (ram_addr !== 8'd0 || ram_wdata !== 32'd0) begin errors++; $display("FAIL clr_bus got %h/%h exp 00/0", ram_addr, ram_wdata); end
        checks++; if ({m0_if.ack, m1_if.ack} !== 2'b00 || xfer_count !== 32'd0) begin errors++; $display("FAIL clr_ack_count got %b/%0d exp 00/0", {m0_if.ack, m1_if.ack}, xfer_count); end
        checks++; if (m0_if.rdata !== 32'd0 || m1_if.rdata !== 32'd0) begin errors++; $display("FAIL clr_rdata got %h/%h exp 0/0", m0_if.rdata, m1_if.rdata); end
        @(posedge clk); @(negedge clk);
        clr = 1'b0; m0_if.req = 0;
        @(negedge clk);
        checks++; if (ram_mem[3] !== 32'h1111_1111) begin errors++; $display("FAIL clr_ram got %h exp 11111111", ram_mem[3]); end
        run_xfer(1, 0, 0, 0, 8'd3, 8'd0, 32'd0, 32'd0);
        ref_complete(1'b0, 1'b0, 8'd3, 32'd0);
        checks++; if ({o_ack0, o_ack1} !== 2'b10 || o_rd0 !== 32'h1111_1111) begin errors++; $display("FAIL clr_next ack/data got %b/%h exp 10/11111111", {o_ack0, o_ack1}, o_rd0); end
        checks++; if (o_count !== 32'd1) begin errors++; $display("FAIL clr_next_count got %0d exp 1", o_count); end
    endtask

    task automatic test_random();
        logic       r0, r1, w0, w1, w, we_w;
        logic [7:0] a0, a1, a_w;
        logic [31:0] d0, d1, d_w;
        int         sel;
        for (int n = 0; n < 40; n++) begin
            sel = int'($urandom_range(1, 3));
            r0 = sel[0]; r1 = sel[1];
            w0 = 1'($urandom_range(0, 1)); w1 = 1'($urandom_range(0, 1));
            a0 = 8'($urandom_range(0, 15)); a1 = 8'($urandom_range(0, 15));
            d0 = $urandom; d1 = $urandom;
            w = ref_pick(r0, r1);
            we_w = w ? w1 : w0; a_w = w ? a1 : a0; d_w = w ? d1 : d0;
            run_xfer(r0, r1, w0, w1, a0, a1, d0, d1);
            ref_complete(w, we_w, a_w, d_w);
            checks++; if ({o_cs, o_rd} !== {1'b1, ~we_w} || o_addr !== a_w || o_wdata !== d_w) begin errors++; $display("FAIL rand_bus #%0d got %b%b %h %h exp 1%b %h %h", n, o_cs, o_rd, o_addr, o_wdata, ~we_w, a_w, d_w); end
            checks++; if ({o_ack0, o_ack1} !== {~w, w}) begin errors++; $display("FAIL rand_ack #%0d got %b exp %b", n, {o_ack0, o_ack1}, {~w, w}); end
            checks++; if (o_rd0 !== exp_rdata[0] || o_rd1 !== exp_rdata[1]) begin errors++; $display("FAIL rand_rdata #%0d got %h/%h exp %h/%h", n, o_rd0, o_rd1, exp_rdata[0], exp_rdata[1]); end
            checks++; if (o_count !== exp_count || o_busy_i !== 1'b0) begin errors++; $display("FAIL rand_count #%0d got %0d/%b exp %0d/0", n, o_count, o_busy_i, exp_count); end
            checks++; if (ram_mem[a_w] !== ref_mem[a_w]) begin errors++; $display("FAIL rand_ram #%0d got %h exp %h", n, ram_mem[a_w], ref_mem[a_w]); end
        end
    endtask

    task automatic test_count_wrap();
        force dut.xfer_count = 32'hFFFF_FFFF;
        @(posedge clk); @(negedge clk);
        release dut.xfer_count;
        exp_count = 32'hFFFF_FFFF;
        run_xfer(0, 1, 0, 1, 8'd0, 8'h40, 32'd0, 32'h0000_0040);
        ref_complete(1'b1, 1'b1, 8'h40, 32'h0000_0040);
        checks++; if (o_count !== 32'd0) begin errors++; $display("FAIL count_wrap got %h exp 0", o_count); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_read();
        test_write_then_read();
        test_tie_hold();
        test_abandon();
        test_clr_mid_grant();
        test_random();
        test_count_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 SHALL provide: clk  input  1  sole clock, all state on posedge.
REQ-002 SHALL provide: clr  input  1  reset, asynchronous, active-high.
REQ-003 SHALL provide: m0_req, m0_we  input  1 each  CPU port request level / write select (1=write).
REQ-004 SHALL provide: m0_addr  input  8, m0_wdata  input  32  CPU word address / write data.
REQ-005 SHALL provide: m0_ack  output  1, m0_rdata  output  32  CPU completion pulse / registered read data.
REQ-006 SHALL provide m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata, identical widths and meanings, for the debug/loader port.
REQ-007 SHALL provide: ram_cs, ram_rd, ram_oe  output  1 each  data RAM strobes; ram_oe always equals ram_rd.
REQ-008 SHALL provide: ram_addr  output  8, ram_wdata  output  32, ram_rdata  input  32 (RAM combinational read, write at posedge when cs=1, rd=0).
REQ-009 SHALL provide: busy  output  1 (state != IDLE); xfer_count  output  32  completed transactions.

Function
REQ-010 SHALL implement FSM states IDLE, GRANT, ACK; grant_sel register (0=m0, 1=m1) names the owner.
REQ-011 IDLE: if any req=1, SHALL latch winner into grant_sel and go GRANT next edge; else stay IDLE.
REQ-012 Tie (both req=1 in IDLE) SHALL be resolved per REQ-024/REQ-025; single requester always wins.
REQ-013 GRANT: ram_cs=1, ram_rd=~we, ram_addr/ram_wdata SHALL mux combinationally from owner's live inputs; other port's inputs ignored.
REQ-014 GRANT, owner req=1: on edge, read SHALL capture ram_rdata into owner's mX_rdata; write SHALL occur in RAM; FSM -> ACK.
REQ-015 GRANT, owner req=0 (abandon): ram_cs SHALL be 0 that cycle; FSM -> IDLE; no ack, no rdata update, no count.
REQ-016 ACK: owner mX_ack=1 for exactly this one cycle; ram_cs=0; xfer_count +1 on exiting edge (wraps 0xFFFFFFFF -> 0); FSM -> IDLE.
REQ-017 Latency SHALL be fixed: req seen in IDLE at cycle N -> RAM access cycle N+1 -> ack cycle N+2; 3 cycles per transaction minimum.
REQ-018 Requests arriving during GRANT/ACK SHALL wait; non-owner ack SHALL stay 0.
REQ-019 Requester SHALL drop req on the edge it samples ack=1; req still high at IDLE starts a new transaction.
REQ-020 mX_rdata SHALL hold its value until the next completed read on that port; writes leave it unchanged.
REQ-021 Outputs ram_*, mX_ack, busy SHALL be glitch-free functions of registered state plus owner inputs only.

Reset
REQ-022 clr=1 SHALL immediately force: state IDLE, ram_cs=0, ram_rd=0, ram_oe=0, ram_addr=0, ram_wdata=0, m0_ack=m1_ack=0, m0_rdata=m1_rdata=0, busy=0, xfer_count=0, grant_sel=0, last_grant=1.
REQ-023 clr asserted during GRANT SHALL abort the access: no RAM write, no ack, no count; first transaction after clr falls starts from IDLE.

Configuration
REQ-024 With DM_ARBITER_RR_EN defined: last_grant register updated at each ACK exit; tie SHALL go to port != last_grant (m0 first after reset).
REQ-025 Without DM_ARBITER_RR_EN: no last_grant register; tie SHALL always go to m0 (fixed priority).

Verification
REQ-026 Single read: RAM[5]=0xDEADBEEF, m0_req=1 we=0 addr=5 at cycle 0 -> ram_cs=1 ram_rd=1 cycle 1, m0_ack=1 m0_rdata=0xDEADBEEF cycle 2, xfer_count=1.
REQ-027 m1 write addr=0x10 data=0x12345678, then m0 read addr=0x10 -> m1_ack cycle 2, m0_ack cycle 5, m0_rdata=0x12345678.
REQ-028 Both req held high for 4 transactions -> with DM_ARBITER_RR_EN acks m0,m1,m0,m1; without, m0 x4 and m1_ack never.
REQ-029 m0 write issued, m0_req dropped in GRANT cycle -> ram_cs=0, RAM unchanged, m0_ack=0, xfer_count unchanged, busy=0 next cycle.
REQ-030 clr pulsed mid-GRANT of write 0xAAAAAAAA to addr 3 -> RAM[3] unchanged, all outputs at REQ-022 values immediately, next request completes normally.
REQ-031 xfer_count preloaded to 0xFFFFFFFF via force, one transaction -> xfer_count=0.
